pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have: clk  input  1  sole clock, all state updates on posedge.
REQ-002 SHALL have: rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have: pc_q  input  8  current PC, read back from the PC register output.
REQ-004 SHALL have: stall  input  1  hold PC this cycle.
REQ-005 SHALL have: branch_taken  input  1, branch_off  input  8  two's-complement relative offset.
REQ-006 SHALL have: jump  input  1, call  input  1, jump_addr  input  8  absolute target for jump/call.
REQ-007 SHALL have: ret  input  1  return to address on top of the return stack.
REQ-008 SHALL have: halt  input  1, resume  input  1.
REQ-009 SHALL have: next_pc  output  8  value for the PC register D input.
REQ-010 SHALL have: fetch_en  output  1  instruction fetch valid this cycle.
REQ-011 SHALL have: ras_ovf  output  1, ras_unf  output  1  sticky return-stack error flags.
REQ-012 SHALL have: st  output  2  state encoding: BOOT=00, RUN=01, HALT=10.
REQ-013 SHALL have parameter RAS_DEPTH, default 4, return-address stack entry count.

Function
REQ-014 SHALL compute next_pc combinationally from state, inputs, pc_q and stack top; all other outputs registered.
REQ-015 SHALL perform all PC arithmetic modulo 256 (8-bit wrap, no carry out).
REQ-016 SHALL in BOOT: next_pc=0x00, fetch_en=0, ignore all control inputs, go to RUN after one cycle.
REQ-017 SHALL in RUN apply priority halt > stall > ret > call > jump > branch_taken > increment.
REQ-018 SHALL on halt in RUN: next_pc=pc_q, fetch_en=0 from next cycle, go to HALT.
REQ-019 SHALL on stall in RUN: next_pc=pc_q, no stack change, stay RUN.
REQ-020 SHALL on ret with non-empty stack: next_pc=top entry, pop one entry.
REQ-021 SHALL on ret with empty stack: next_pc=pc_q+1, set ras_unf, no pop.
REQ-022 SHALL on call with stack not full: push pc_q+1, next_pc=jump_addr.
REQ-023 SHALL on call with full stack: next_pc=jump_addr, discard push, set ras_ovf.
REQ-024 SHALL on jump: next_pc=jump_addr; on branch_taken: next_pc=pc_q+branch_off (sign-extended).
REQ-025 SHALL otherwise in RUN: next_pc=pc_q+1.
REQ-026 SHALL drive fetch_en=1 in RUN, 0 in BOOT and HALT.
REQ-027 SHALL in HALT: next_pc=pc_q, no stack change; on resume go RUN with next_pc=pc_q in the resume cycle (no advance).
REQ-028 SHALL treat simultaneous call and ret as ret only (priority); stack depth never exceeds RAS_DEPTH.
REQ-029 SHALL keep ras_ovf/ras_unf set until reset once asserted.
REQ-030 SHALL treat st=11 as illegal and recover to BOOT on the next edge.

Reset
REQ-031 SHALL, when rst_n=0 at a posedge: st=BOOT, stack empty, ras_ovf=0, ras_unf=0, fetch_en=0.
REQ-032 SHALL drive next_pc=0x00 combinationally whenever rst_n=0, independent of state.
REQ-033 SHALL abort any operation on reset mid-run (including HALT, pending pushes) with no residual stack contents.

Verification
REQ-034 Reset then free-run, pc_q fed back from a register: PC sequence 0x00,0x00(BOOT),0x01,0x02..., 0xFF wraps to 0x00, fetch_en=1 from RUN.
REQ-035 pc_q=0x10, branch_taken, branch_off=0xF0 -> next_pc=0x00; same with stall=1 -> next_pc=0x10.
REQ-036 pc_q=0x20 call jump_addr=0x80; later pc_q=0x85 ret -> next_pc=0x21; ret again on empty -> next_pc=0x86, ras_unf=1.
REQ-037 Five nested calls with RAS_DEPTH=4 -> fifth call jumps, ras_ovf=1; four rets return in LIFO order.
REQ-038 pc_q=0x40 halt -> st=HALT, next_pc=0x40, fetch_en=0; resume -> st=RUN, next_pc=0x40, then 0x41.
REQ-039 rst_n=0 while in HALT with two stack entries -> st=BOOT, next_pc=0x00, flags clear, ret after BOOT sets ras_unf.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generator with return-address stack and halt/resume.
//
// Ports
//   clk           sole clock, all state updates on posedge
//   rst_n         synchronous active-low reset
//   pc_q [7:0]    current PC, fed back from the external PC register
//   stall         hold PC this cycle
//   branch_taken  take relative branch; branch_off [7:0] is two's complement
//   jump, call    absolute transfer to jump_addr [7:0]; call also pushes pc_q+1
//   ret           return to top of the return stack
//   halt, resume  stop / restart fetching
//   next_pc [7:0] D input of the PC register (combinational)
//   fetch_en      instruction fetch valid (registered)
//   ras_ovf       sticky: call attempted with the stack full
//   ras_unf       sticky: ret attempted with the stack empty
//   st [1:0]      state: BOOT=00, RUN=01, HALT=10
//
// state | meaning
// BOOT  | one cycle after reset, PC forced to 0x00, no fetch
// RUN   | normal sequencing, fetch enabled
// HALT  | PC held, no fetch, waits for resume
// (11)  | illegal, recovers to BOOT on the next edge

module pc_sequencer #(
   parameter int RAS_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] pc_q,
   input  logic       stall,
   input  logic       branch_taken,
   input  logic [7:0] branch_off,
   input  logic       jump,
   input  logic       call,
   input  logic [7:0] jump_addr,
   input  logic       ret,
   input  logic       halt,
   input  logic       resume,
   output logic [7:0] next_pc,
   output logic       fetch_en,
   output logic       ras_ovf,
   output logic       ras_unf,
   output logic [1:0] st
);

   localparam int SPW = $clog2(RAS_DEPTH + 1);

   typedef enum logic [1:0] {
      S_BOOT = 2'b00,
      S_RUN  = 2'b01,
      S_HALT = 2'b10
   } state_t;

   state_t         state;
   logic [7:0]     ras [RAS_DEPTH];
   logic [SPW-1:0] sp;
   logic [7:0]     pc_inc;
   logic [7:0]     pc_br;
   logic [7:0]     ras_top;
   logic           ras_empty;
   logic           ras_full;

   assign pc_inc    = pc_q + 8'd1;
   // An 8-bit add of the raw offset is the sign-extended add modulo 256.
   assign pc_br     = pc_q + branch_off;
   assign ras_empty = (sp == '0);
   assign ras_full  = (sp == SPW'(RAS_DEPTH));
   assign st        = state;

   // Entry i holds the (i+1)-th pushed address; top sits at index sp-1.
   always_comb begin
      ras_top = 8'h00;
      for (int i = 0; i < RAS_DEPTH; i++) begin
         if (SPW'(i + 1) == sp) ras_top = ras[i];
      end
   end

   always_comb begin
      next_pc = 8'h00;
      if (rst_n) begin
         case (state)
            S_BOOT: next_pc = 8'h00;
            S_RUN: begin
               if (halt || stall)    next_pc = pc_q;
               else if (ret)         next_pc = ras_empty ? pc_inc : ras_top;
               else if (call || jump) next_pc = jump_addr;
               else if (branch_taken) next_pc = pc_br;
               else                  next_pc = pc_inc;
            end
            S_HALT: next_pc = pc_q;
            default: next_pc = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_BOOT;
         sp       <= '0;
         ras_ovf  <= 1'b0;
         ras_unf  <= 1'b0;
         fetch_en <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= 8'h00;
      end else begin
         case (state)
            S_BOOT: begin
               state    <= S_RUN;
               fetch_en <= 1'b1;
            end
            S_RUN: begin
               if (halt) begin
                  state    <= S_HALT;
                  fetch_en <= 1'b0;
               end else if (!stall) begin
                  if (ret) begin
                     if (ras_empty) ras_unf <= 1'b1;
                     else           sp      <= sp - SPW'(1);
                  end else if (call) begin
                     if (ras_full) begin
                        ras_ovf <= 1'b1;
                     end else begin
                        for (int i = 0; i < RAS_DEPTH; i++) begin
                           if (SPW'(i) == sp) ras[i] <= pc_inc;
                        end
                        sp <= sp + SPW'(1);
                     end
                  end
               end
            end
            S_HALT: begin
               if (resume) begin
                  state    <= S_RUN;
                  fetch_en <= 1'b1;
               end
            end
            default: begin
               state    <= S_BOOT;
               fetch_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus a randomized run
// checked against a queue-based behavioural model.

module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pc_q;
   logic       stall, branch_taken, jump, call, ret, halt, resume;
   logic [7:0] branch_off, jump_addr;
   logic [7:0] next_pc;
   logic       fetch_en, ras_ovf, ras_unf;
   logic [1:0] st;

   logic       fb;
   logic [7:0] pc_drv, pc_reg;

   int checks = 0;
   int errors = 0;

   // behavioural model: mode 0=BOOT 1=RUN 2=HALT
   logic [1:0] m_mode;
   logic [7:0] m_stack[$];
   logic       m_ovf, m_unf;

   always #5 clk = ~clk;

   assign pc_q = fb ? pc_reg : pc_drv;
   always @(posedge clk) pc_reg <= next_pc;

   pc_sequencer #(.RAS_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .pc_q(pc_q), .stall(stall),
      .branch_taken(branch_taken), .branch_off(branch_off),
      .jump(jump), .call(call), .jump_addr(jump_addr), .ret(ret),
      .halt(halt), .resume(resume), .next_pc(next_pc),
      .fetch_en(fetch_en), .ras_ovf(ras_ovf), .ras_unf(ras_unf), .st(st)
   );

   function automatic logic [7:0] model_npc();
      logic [7:0] r;
      if (!rst_n) r = 8'h00;
      else if (m_mode == 2'd0) r = 8'h00;
      else if (m_mode == 2'd2) r = pc_q;
      else if (halt || stall) r = pc_q;
      else if (ret) r = (m_stack.size() > 0) ? m_stack[$] : 8'(pc_q + 8'd1);
      else if (call || jump) r = jump_addr;
      else if (branch_taken) r = 8'(int'(pc_q) + int'($signed(branch_off)));
      else r = 8'(pc_q + 8'd1);
      return r;
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         m_mode = 2'd0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else if (m_mode == 2'd0) begin
         m_mode = 2'd1;
      end else if (m_mode == 2'd2) begin
         if (resume) m_mode = 2'd1;
      end else if (halt) begin
         m_mode = 2'd2;
      end else if (!stall) begin
         if (ret) begin
            if (m_stack.size() > 0) void'(m_stack.pop_back());
            else m_unf = 1'b1;
         end else if (call) begin
            if (m_stack.size() < 4) m_stack.push_back(8'(pc_q + 8'd1));
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
      halt = 0; resume = 0; branch_off = 8'h00; jump_addr = 8'h00;
   endtask

   task automatic do_reset();
      clear_ctl();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      fb = 1'b0; pc_drv = 8'h5A;
      clear_ctl();
      rst_n = 1'b0;
      #1;
      checks++;
      if (next_pc !== 8'h00) begin errors++; $display("FAIL reset_npc: got %h exp 00", next_pc); end
      tick();
      checks++;
      if ({st, fetch_en, ras_ovf, ras_unf} !== 5'b00000) begin
         errors++; $display("FAIL reset_state: st=%b fe=%b ovf=%b unf=%b exp all 0", st, fetch_en, ras_ovf, ras_unf);
      end
   endtask

   task automatic test_free_run();
      fb = 1'b1;
      do_reset();
      for (int k = 0; k < 262; k++) begin
         checks++;
         if (next_pc !== ((k == 0) ? 8'h00 : 8'(k))) begin
            errors++; $display("FAIL free_run_npc k=%0d: got %h exp %h", k, next_pc, (k == 0) ? 8'h00 : 8'(k));
         end
         checks++;
         if (fetch_en !== (k != 0)) begin
            errors++; $display("FAIL free_run_fetch k=%0d: got %b exp %b", k, fetch_en, k != 0);
         end
         tick();
      end
      fb = 1'b0;
   endtask

   task automatic test_branch();
      pc_drv = 8'h10; branch_taken = 1; branch_off = 8'hF0;
      #1;
      checks++;
      if (next_pc !== 8'h00) begin errors++; $display("FAIL branch_back: got %h exp 00", next_pc); end
      stall = 1;
      #1;
      checks++;
      if (next_pc !== 8'h10) begin errors++; $display("FAIL branch_stall: got %h exp 10", next_pc); end
      stall = 0; branch_off = 8'h7F; pc_drv = 8'hF0;
      #1;
      checks++;
      if (next_pc !== 8'h6F) begin errors++; $display("FAIL branch_fwd_wrap: got %h exp 6f", next_pc); end
      clear_ctl();
   endtask

   task automatic test_call_ret();
      do_reset();
      tick();
      pc_drv = 8'h20; call = 1; jump_addr = 8'h80;
      #1;
      checks++;
      if (next_pc !== 8'h80) begin errors++; $display("FAIL call_target: got %h exp 80", next_pc); end
      tick();
      clear_ctl();
      pc_drv = 8'h85; ret = 1;
      #1;
      checks++;
      if (next_pc !== 8'h21) begin errors++; $display("FAIL ret_top: got %h exp 21", next_pc); end
      tick();
      #1;
      checks++;
      if (next_pc !== 8'h86) begin errors++; $display("FAIL ret_empty_npc: got %h exp 86", next_pc); end
      tick();
      checks++;
      if (ras_unf !== 1'b1 || ras_ovf !== 1'b0) begin
         errors++; $display("FAIL ret_empty_flag: unf=%b ovf=%b exp unf=1 ovf=0", ras_unf, ras_ovf);
      end
      clear_ctl();
   endtask

   task automatic test_overflow();
      logic [7:0] exp_ret [4];
      do_reset();
      tick();
      for (int i = 1; i <= 5; i++) begin
         pc_drv = 8'(i * 16); call = 1; jump_addr = 8'(8'h50 + i);
         #1;
         checks++;
         if (next_pc !== jump_addr) begin errors++; $display("FAIL nest_call%0d: got %h exp %h", i, next_pc, jump_addr); end
         tick();
      end
      checks++;
      if (ras_ovf !== 1'b1 || ras_unf !== 1'b0) begin
         errors++; $display("FAIL nest_ovf: ovf=%b unf=%b exp ovf=1 unf=0", ras_ovf, ras_unf);
      end
      clear_ctl();
      exp_ret[0] = 8'h41; exp_ret[1] = 8'h31; exp_ret[2] = 8'h21; exp_ret[3] = 8'h11;
      for (int i = 0; i < 4; i++) begin
         pc_drv = 8'($urandom_range(0, 255)); ret = 1;
         #1;
         checks++;
         if (next_pc !== exp_ret[i]) begin errors++; $display("FAIL lifo_ret%0d: got %h exp %h", i, next_pc, exp_ret[i]); end
         tick();
      end
      checks++;
      if (ras_unf !== 1'b0 || ras_ovf !== 1'b1) begin
         errors++; $display("FAIL lifo_flags: unf=%b ovf=%b exp unf=0 ovf=1", ras_unf, ras_ovf);
      end
      clear_ctl();
   endtask

   task automatic test_halt();
      pc_drv = 8'h40; halt = 1;
      #1;
      checks++;
      if (next_pc !== 8'h40) begin errors++; $display("FAIL halt_npc: got %h exp 40", next_pc); end
      tick();
      halt = 0; jump = 1; jump_addr = 8'h99;
      #1;
      checks++;
      if (st !== 2'b10 || fetch_en !== 1'b0 || next_pc !== 8'h40) begin
         errors++; $display("FAIL halt_state: st=%b fe=%b npc=%h exp st=10 fe=0 npc=40", st, fetch_en, next_pc);
      end
      jump = 0; resume = 1;
      #1;
      checks++;
      if (next_pc !== 8'h40) begin errors++; $display("FAIL resume_npc: got %h exp 40", next_pc); end
      tick();
      resume = 0;
      #1;
      checks++;
      if (st !== 2'b01 || fetch_en !== 1'b1 || next_pc !== 8'h41) begin
         errors++; $display("FAIL resume_run: st=%b fe=%b npc=%h exp st=01 fe=1 npc=41", st, fetch_en, next_pc);
      end
      clear_ctl();
   endtask

   task automatic test_reset_in_halt();
      do_reset();
      tick();
      for (int i = 0; i < 2; i++) begin
         pc_drv = 8'(8'h60 + i); call = 1; jump_addr = 8'h70;
         tick();
      end
      clear_ctl();
      halt = 1;
      tick();
      halt = 0;
      rst_n = 0;
      #1;
      checks++;
      if (next_pc !== 8'h00) begin errors++; $display("FAIL rst_comb_npc: got %h exp 00", next_pc); end
      tick();
      checks++;
      if ({st, fetch_en, ras_ovf, ras_unf} !== 5'b00000) begin
         errors++; $display("FAIL rst_halt_state: st=%b fe=%b ovf=%b unf=%b exp all 0", st, fetch_en, ras_ovf, ras_unf);
      end
      rst_n = 1;
      tick();
      pc_drv = 8'h33; ret = 1;
      #1;
      checks++;
      if (next_pc !== 8'h34) begin errors++; $display("FAIL rst_halt_ret_npc: got %h exp 34", next_pc); end
      tick();
      checks++;
      if (ras_unf !== 1'b1) begin errors++; $display("FAIL rst_halt_unf: got %b exp 1", ras_unf); end
      clear_ctl();
   endtask

   task automatic test_random();
      logic [7:0] exp_npc;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst_n        = ($urandom_range(0, 99) != 0);
         pc_drv       = 8'($urandom_range(0, 255));
         halt         = ($urandom_range(0, 99) < 4);
         resume       = ($urandom_range(0, 99) < 30);
         stall        = ($urandom_range(0, 99) < 10);
         ret          = ($urandom_range(0, 99) < 25);
         call         = ($urandom_range(0, 99) < 30);
         jump         = ($urandom_range(0, 99) < 10);
         branch_taken = ($urandom_range(0, 99) < 30);
         branch_off   = 8'($urandom_range(0, 255));
         jump_addr    = 8'($urandom_range(0, 255));
         #1;
         exp_npc = model_npc();
         checks++;
         if (next_pc !== exp_npc) begin
            errors++; $display("FAIL rand_npc n=%0d: got %h exp %h", n, next_pc, exp_npc);
         end
         tick();
         checks++;
         if (st !== m_mode || fetch_en !== (m_mode == 2'd1) || ras_ovf !== m_ovf || ras_unf !== m_unf) begin
            errors++;
            $display("FAIL rand_regs n=%0d: st=%b fe=%b ovf=%b unf=%b exp st=%b fe=%b ovf=%b unf=%b",
                     n, st, fetch_en, ras_ovf, ras_unf, m_mode, m_mode == 2'd1, m_ovf, m_unf);
         end
      end
      clear_ctl();
      rst_n = 1'b1;
   endtask

   initial begin
      fb = 1'b0; pc_drv = 8'h00; rst_n = 1'b0;
      m_mode = 2'd0; m_ovf = 1'b0; m_unf = 1'b0;
      clear_ctl();
      @(posedge clk);
      #1;
      test_reset();
      test_free_run();
      test_branch();
      test_call_ret();
      test_overflow();
      do_reset();
      tick();
      test_halt();
      test_reset_in_halt();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
